// File: rtl/serial_arith_pkg.sv
// Shared types for the chunk-serial arithmetic blocks.
package serial_arith_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    // Chunk counter width; a single-chunk operand still gets a 1-bit counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// W-bit ripple-carry adder built from a chain of full-adder cells.
module chunk_adder #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    logic [W:0] cy;

    assign cy[0] = cin;
    assign cout  = cy[W];

    for (genvar i = 0; i < W; i++) begin : g_bit
        fa_cell u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (cy[i]),
            .s    (s[i]),
            .cout (cy[i+1])
        );
    end

endmodule

// File: rtl/fa_cell.sv
// Single-bit full adder cell.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Chunk-serial adder/subtractor: operands arrive LS chunk first, one result
// chunk is registered per accepted input chunk, carry threads between chunks.
//
// state | meaning
// IDLE  | waiting for start; in_valid alone is ignored
// RUN   | accepting chunks 1..CC-1 (or chunk 0 if start came without data)
module serial_addsub
    import serial_arith_pkg::*;
#(
    parameter int W  = 4,
    parameter int CC = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic         in_valid,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] c,
    output logic         out_valid,
    output logic         last,
    output logic         carry_out,
    output logic         busy
);

    localparam int CW = cnt_width(CC);

    state_e        state_q, state_d;
    mode_e         mode_q, mode_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cy_q, cy_d;
    logic [W-1:0]  c_q, c_d;
    logic          out_valid_q, out_valid_d;
    logic          last_q, last_d;
    logic          carry_out_q, carry_out_d;

    logic          idle, starting, accept;
    mode_e         mode_cur;
    logic          cin_cur;
    logic [W-1:0]  b_eff, sum;
    logic          sum_cy;

    // On the start cycle the freshly sampled mode/carry-in are used directly,
    // so chunk 0 may arrive together with start.
    assign idle     = (state_q == ST_IDLE);
    assign starting = idle && start;
    assign accept   = in_valid && (!idle || start);
    assign mode_cur = starting ? mode_e'(sub) : mode_q;
    assign cin_cur  = starting ? sub : cy_q;
    assign b_eff    = (mode_cur == MODE_SUB) ? ~b : b;

    chunk_adder #(.W(W)) u_add (
        .a    (a),
        .b    (b_eff),
        .cin  (cin_cur),
        .s    (sum),
        .cout (sum_cy)
    );

    // Next-state: start latches mode/carry, each accepted chunk advances the count.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        cy_d        = cy_q;
        c_d         = c_q;
        out_valid_d = 1'b0;
        last_d      = 1'b0;
        carry_out_d = carry_out_q;

        if (starting) begin
            state_d = ST_RUN;
            mode_d  = mode_cur;
            cy_d    = cin_cur;
            cnt_d   = '0;
        end

        if (accept) begin
            c_d         = sum;
            out_valid_d = 1'b1;
            cy_d        = sum_cy;
            if (cnt_q == CW'(CC - 1)) begin
                cnt_d       = '0;
                state_d     = ST_IDLE;
                last_d      = 1'b1;
                carry_out_d = sum_cy;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_ADD;
            cnt_q       <= '0;
            cy_q        <= 1'b0;
            c_q         <= '0;
            out_valid_q <= 1'b0;
            last_q      <= 1'b0;
            carry_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            cy_q        <= cy_d;
            c_q         <= c_d;
            out_valid_q <= out_valid_d;
            last_q      <= last_d;
            carry_out_q <= carry_out_d;
        end
    end

    assign c         = c_q;
    assign out_valid = out_valid_q;
    assign last      = last_q;
    assign carry_out = carry_out_q;
    assign busy      = (state_q == ST_RUN);

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench: instance A is W=4/CC=2, instance B is W=8/CC=64.
module tb_serial_addsub;

    typedef struct {
        logic [7:0] c;
        logic       last;
        logic       cy;
    } exp_t;

    logic       clk;
    logic       rst;

    logic       start_a, sub_a, iv_a;
    logic [3:0] a_a, b_a, c_a;
    logic       ov_a, last_a, co_a, busy_a;

    logic       start_b, sub_b, iv_b;
    logic [7:0] a_b, b_b, c_b;
    logic       ov_b, last_b, co_b, busy_b;

    exp_t q_a[$];
    exp_t q_b[$];

    int  errors = 0;
    int  checks = 0;
    bit  done   = 1'b0;

    serial_addsub #(.W(4), .CC(2)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .sub(sub_a), .in_valid(iv_a),
        .a(a_a), .b(b_a), .c(c_a), .out_valid(ov_a), .last(last_a),
        .carry_out(co_a), .busy(busy_a)
    );

    serial_addsub #(.W(8), .CC(64)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .sub(sub_b), .in_valid(iv_b),
        .a(a_b), .b(b_b), .c(c_b), .out_valid(ov_b), .last(last_b),
        .carry_out(co_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: sole owner of the counters; pops expectations on out_valid.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            check("rst_a_outs", {56'd0, c_a, ov_a, last_a, co_a, busy_a}, 64'd0);
            check("rst_b_outs", {52'd0, c_b, ov_b, last_b, co_b, busy_b}, 64'd0);
        end else begin
            if (ov_a) begin
                if (q_a.size() == 0) begin
                    check("a_unexpected_out", 64'd1, 64'd0);
                end else begin
                    e = q_a.pop_front();
                    check("a_c", 64'(c_a), 64'(e.c));
                    check("a_last", 64'(last_a), 64'(e.last));
                    if (e.last) check("a_carry_out", 64'(co_a), 64'(e.cy));
                end
            end
            if (ov_b) begin
                if (q_b.size() == 0) begin
                    check("b_unexpected_out", 64'd1, 64'd0);
                end else begin
                    e = q_b.pop_front();
                    check("b_c", 64'(c_b), 64'(e.c));
                    check("b_last", 64'(last_b), 64'(e.last));
                    if (e.last) check("b_carry_out", 64'(co_b), 64'(e.cy));
                end
            end
            if (done) begin
                check("a_missing_outs", 64'(q_a.size()), 64'd0);
                check("b_missing_outs", 64'(q_b.size()), 64'd0);
                check("a_busy_end", 64'(busy_a), 64'd0);
                check("b_busy_end", 64'(busy_b), 64'd0);
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs(input int sel);
        if (sel == 0) begin
            start_a = 1'b0; iv_a = 1'b0; a_a = 4'($urandom); b_a = 4'($urandom);
        end else begin
            start_b = 1'b0; iv_b = 1'b0; a_b = 8'($urandom); b_b = 8'($urandom);
        end
    endtask

    // Reference: whole-operand (a +/- b) mod 2^(W*CC); expected chunks are
    // pushed, then the first n_drv chunks are driven. start stays high and sub
    // is inverted after chunk 0 to show both are ignored during RUN.
    task automatic run_op(input int sel, input logic [511:0] av_in, input logic [511:0] bv_in,
                          input logic s, input int stall_at, input int stall_len, input int n_drv);
        int w, cc, opw;
        logic [511:0] mask, av, bv, res;
        logic [512:0] full;
        logic cout;
        logic [7:0] cmask, ach, bch;
        exp_t e;
        w = (sel == 0) ? 4 : 8;
        cc = (sel == 0) ? 2 : 64;
        opw = w * cc;
        cmask = (sel == 0) ? 8'h0F : 8'hFF;
        mask = '0;
        for (int k = 0; k < opw; k++) mask[k] = 1'b1;
        av = av_in & mask;
        bv = bv_in & mask;
        if (!s) begin
            full = {1'b0, av} + {1'b0, bv};
            cout = full[opw];
        end else begin
            full = {1'b0, av} + {1'b0, (~bv) & mask} + 513'd1;
            cout = (av >= bv);
        end
        res = full[511:0] & mask;
        for (int i = 0; i < n_drv; i++) begin
            e.c = 8'(res >> (i * w)) & cmask;
            e.last = (i == cc - 1);
            e.cy = cout;
            if (sel == 0) q_a.push_back(e); else q_b.push_back(e);
        end
        for (int i = 0; i < n_drv; i++) begin
            ach = 8'(av >> (i * w));
            bch = 8'(bv >> (i * w));
            if (sel == 0) begin
                start_a = 1'b1; sub_a = (i == 0) ? s : ~s; iv_a = 1'b1;
                a_a = ach[3:0]; b_a = bch[3:0];
            end else begin
                start_b = 1'b1; sub_b = (i == 0) ? s : ~s; iv_b = 1'b1;
                a_b = ach; b_b = bch;
            end
            @(posedge clk); #1;
            if (i == stall_at) begin
                repeat (stall_len) begin
                    idle_inputs(sel);
                    @(posedge clk); #1;
                end
            end
        end
        idle_inputs(sel);
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    initial begin
        logic [511:0] ra, rb;
        rst = 1'b0;
        sub_a = 1'b0; sub_b = 1'b0;
        idle_inputs(0);
        idle_inputs(1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // in_valid without start in IDLE must not produce output
        iv_a = 1'b1; a_a = 4'hF; b_a = 4'hF;
        repeat (2) @(posedge clk);
        #1 idle_inputs(0);
        @(posedge clk); #1;

        run_op(0, 512'h0F, 512'h01, 1'b0, -1, 0, 2);   // c={0,1}, carry 0
        @(posedge clk); #1;
        run_op(0, 512'h03, 512'h05, 1'b1, -1, 0, 2);   // c={E,F}, borrow
        @(posedge clk); #1;
        run_op(0, 512'h05, 512'h03, 1'b1, -1, 0, 2);   // c={2,0}, carry 1
        @(posedge clk); #1;
        run_op(0, 512'h9F, 512'h78, 1'b0, 0, 3, 2);    // stalled: 0x17, carry 1
        @(posedge clk); #1;
        run_op(0, 512'h9F, 512'h78, 1'b0, -1, 0, 2);   // same, unstalled
        // back-to-back, no bubble
        run_op(0, 512'hFF, 512'h01, 1'b0, -1, 0, 2);
        run_op(0, 512'h80, 512'h80, 1'b1, -1, 0, 2);
        run_op(0, 512'h00, 512'hFF, 1'b1, -1, 0, 2);
        repeat (2) @(posedge clk); #1;

        // W=8, CC=64 regression
        run_op(1, rand512(), rand512(), 1'b0, -1, 0, 64);
        run_op(1, rand512(), rand512(), 1'b1, -1, 0, 64);
        @(posedge clk); #1;
        run_op(1, rand512(), rand512(), 1'b0, 10, 3, 64);
        run_op(1, '1, 512'd1, 1'b0, -1, 0, 64);        // full ripple, carry 1
        ra = rand512();
        run_op(1, ra, ra, 1'b1, -1, 0, 64);            // equal, no borrow
        run_op(1, 512'd7, rand512() | (512'd1 << 511), 1'b1, -1, 0, 64);
        @(posedge clk); #1;

        // reset after chunk 0 of an add, then a fresh op
        run_op(1, rand512(), rand512(), 1'b0, -1, 0, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        run_op(1, rand512(), rand512(), 1'b0, -1, 0, 64);
        run_op(1, rand512(), rand512(), 1'b1, 30, 2, 64);
        run_op(1, rand512(), rand512(), 1'b0, -1, 0, 64);

        repeat (4) @(posedge clk);
        #1 done = 1'b1;
    end

endmodule
